// File: rtl/tt_proj_sel.sv
// Project selector: pad-strobed address picks one of N_PROJ wrappers, forwards pad I/O to it.
// Optional macro TT_PROJ_SEL_LIVE_SWITCH_EN lets the address move while a project is enabled.
module tt_proj_sel #(
  parameter int N_PROJ   = 24,
  parameter int ADDR_W   = 5,
  parameter int RST_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel_inc,
  input  logic                 sel_clr,
  input  logic                 sel_ena,
  input  logic                 pad_clk,
  input  logic                 pad_rst_n,
  input  logic [7:0]           pad_ui_in,
  input  logic [7:0]           pad_uio_in,
  output logic [7:0]           pad_uo_out,
  output logic [7:0]           pad_uio_out,
  output logic [7:0]           pad_uio_oe,
  output logic [N_PROJ-1:0]    proj_ena,
  output logic [18*N_PROJ-1:0] proj_iw,
  input  logic [24*N_PROJ-1:0] proj_ow,
  output logic [ADDR_W-1:0]    sel_addr
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;

  // One extra bit so N_PROJ == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] N_PROJ_W  = (ADDR_W+1)'(N_PROJ);
  localparam logic [3:0]      HOLD_LAST = 4'(RST_HOLD - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        cnt;
  logic [1:0]        inc_sync, clr_sync, ena_sync;
  logic              inc_dly;
  logic              inc_rise, clr_s, ena_s, addr_upd, addr_ok;
  logic [ADDR_W-1:0] addr_nxt;
  logic [23:0]       ow_sel, out_q;
  logic              fwd_rst_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_sync <= '0;
      clr_sync <= '0;
      ena_sync <= '0;
      inc_dly  <= 1'b0;
    end else begin
      inc_sync <= {inc_sync[0], sel_inc};
      clr_sync <= {clr_sync[0], sel_clr};
      ena_sync <= {ena_sync[0], sel_ena};
      inc_dly  <= inc_sync[1];
    end
  end

  assign inc_rise = inc_sync[1] & ~inc_dly;
  assign clr_s    = clr_sync[1];
  assign ena_s    = ena_sync[1];
  assign addr_upd = clr_s | inc_rise;
  assign addr_nxt = clr_s ? '0 : addr + ADDR_W'(1);
  assign addr_ok  = {1'b0, addr} < N_PROJ_W;

  always_comb begin
    ow_sel = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (addr == ADDR_W'(k)) ow_sel = proj_ow[24*k +: 24];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_q <= '0;
          cnt   <= '0;
          // An address change defers enabling by a cycle so HOLD always sees the new address.
          if (addr_upd)
            addr <= addr_nxt;
          else if (ena_s && addr_ok)
            state <= HOLD;
        end
        HOLD, RUN: begin
          if (!ena_s) begin
            state <= IDLE;
            cnt   <= '0;
            out_q <= '0;
          end
`ifdef TT_PROJ_SEL_LIVE_SWITCH_EN
          else if (addr_upd) begin
            addr  <= addr_nxt;
            cnt   <= '0;
            out_q <= '0;
            state <= ({1'b0, addr_nxt} < N_PROJ_W) ? HOLD : IDLE;
          end
`endif
          else begin
            out_q <= ow_sel;
            if (state == HOLD) begin
              if (cnt == HOLD_LAST) begin
                state <= RUN;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel_addr = addr;
  assign {pad_uio_oe, pad_uio_out, pad_uo_out} = out_q;
  assign fwd_rst_n = (state == RUN) & pad_rst_n;

  // Enables and forwarding decode straight from state, so reset clears them without a clock.
  always_comb begin
    proj_ena = '0;
    proj_iw  = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (state != IDLE && addr == ADDR_W'(k)) begin
        proj_ena[k]          = 1'b1;
        proj_iw[18*k +: 18]  = {pad_uio_in, pad_ui_in, fwd_rst_n, pad_clk};
      end
    end
  end

endmodule

// File: doc/tt_proj_sel.md
TT_PROJ_SEL -- requirements
Module: tt_proj_sel

Interface
Parameters
- REQ-001: N_PROJ, default 24; number of attached project wrappers.
- REQ-002: ADDR_W, default 5; project address width (2^ADDR_W >= N_PROJ).
- REQ-003: RST_HOLD, default 4; cycles of forced project reset after enable, range 1..15.

Ports (name  direction  width  meaning)
- REQ-004: clk  in  1  controller clock; all state on rising edge.
- REQ-005: rst  in  1  asynchronous active-high reset.
- REQ-006: sel_inc  in  1  asynchronous pad strobe; each rising edge increments the address.
- REQ-007: sel_clr  in  1  asynchronous pad level; high clears the address.
- REQ-008: sel_ena  in  1  asynchronous pad level; high requests run of the addressed project.
- REQ-009: pad_clk, pad_rst_n  in  1 each  user clock and user reset to forward.
- REQ-010: pad_ui_in, pad_uio_in  in  8 each  user inputs to forward.
- REQ-011: pad_uo_out, pad_uio_out, pad_uio_oe  out  8 each  selected project outputs.
- REQ-012: proj_ena  out  N_PROJ  one-hot project enable.
- REQ-013: proj_iw  out  18*N_PROJ  per-project input word {uio_in, ui_in, rst_n, clk}, slice k at [18k+17:18k].
- REQ-014: proj_ow  in  24*N_PROJ  per-project output word {uio_oe, uio_out, uo_out}, slice k at [24k+23:24k].
- REQ-015: sel_addr  out  ADDR_W  current address, for debug.

Function
- REQ-016: sel_inc, sel_clr and sel_ena SHALL each pass a 2-flop synchronizer; sel_inc SHALL be rising-edge detected after synchronization (one count per edge).
- REQ-017: FSM states SHALL be IDLE, HOLD, RUN.
- REQ-018: IDLE: proj_ena all zero; synced sel_clr high sets address to 0; detected sel_inc increments address, wrapping 2^ADDR_W-1 -> 0; sel_clr has priority over a same-cycle sel_inc.
- REQ-019: IDLE -> HOLD when synced sel_ena is high and address < N_PROJ; address >= N_PROJ SHALL keep IDLE.
- REQ-020: HOLD: proj_ena[address] high; that project's rst_n forced 0; a counter counts RST_HOLD cycles, then HOLD -> RUN.
- REQ-021: RUN: proj_ena[address] high; rst_n = pad_rst_n.
- REQ-022: HOLD or RUN -> IDLE in the cycle after synced sel_ena is low; proj_ena clears with the transition.
- REQ-023: Enabled slice: clk = pad_clk, ui_in/uio_in = pad inputs (combinational forwarding); all non-enabled slices SHALL be driven to all zero.
- REQ-024: pad outputs SHALL be the selected proj_ow slice registered once in clk (1-cycle latency) while in HOLD/RUN, and zero in IDLE.
- REQ-025: Address SHALL change only in IDLE (see Configuration).

Reset
- REQ-026: rst asserted SHALL immediately force state IDLE, address 0, hold counter 0, synchronizers 0, proj_ena 0, pad outputs 0, all proj_iw 0.
- REQ-027: rst deassert mid-run SHALL leave the block in IDLE; a new sel_ena rising requirement is not imposed -- sel_ena still high re-enters HOLD.

Configuration
- REQ-028: Macro TT_PROJ_SEL_LIVE_SWITCH_EN.
- REQ-029: Defined: in HOLD/RUN, sel_clr or sel_inc SHALL update the address as in IDLE and force HOLD for the new address (RST_HOLD restarted); new address >= N_PROJ SHALL go to IDLE.
- REQ-030: Undefined: sel_clr/sel_inc SHALL be ignored in HOLD/RUN and address held.

Verification
- REQ-031: rst, 5 sel_inc pulses, sel_ena=1 -> sel_addr=5, proj_ena=1<<5 after sync, proj_iw slice 5 rst_n=0 for 4 cycles then follows pad_rst_n.
- REQ-032: address 5 RUN, proj_ow slice 5=24'hA5C3_3C -> pad_uio_oe=A5, pad_uio_out=C3, pad_uo_out=3C one cycle later; other slices ignored.
- REQ-033: 31 sel_inc pulses then 1 more -> sel_addr 31 then 0; sel_ena at 31 (N_PROJ=24) -> stays IDLE, proj_ena=0.
- REQ-034: sel_clr and sel_inc edge same cycle at address 7 -> address 0.
- REQ-035: RUN at address 3, sel_inc pulse -> macro undefined: address stays 3, RUN; defined: address 4, proj_ena=1<<4, 4 hold cycles.
- REQ-036: rst asserted during RUN -> proj_ena, pad outputs, proj_iw zero without waiting for clk.
